// File: rtl/mux6_1.sv
// Registered 6:1 selector for ALU results. Unmapped select codes produce zero and raise selecaoInvalida.
// Outputs change only on a clock edge while enabled, or immediately on reset.
module mux6_1 #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] entrada1,
    input  logic [WIDTH-1:0] entrada2,
    input  logic [WIDTH-1:0] entrada3,
    input  logic [WIDTH-1:0] entrada4,
    input  logic [WIDTH-1:0] entrada5,
    input  logic [WIDTH-1:0] entrada6,
    input  logic [0:3]       unidadeControle,
    output logic [WIDTH-1:0] saida,
    input  logic             habilita,
    output logic             selecaoInvalida,
    output logic             zero
);

    logic [WIDTH-1:0] selData;
    logic             selInvalid;

    // X/Z code bits match no item and fall through to the invalid default.
    always_comb begin
        selData    = '0;
        selInvalid = 1'b0;
        case (unidadeControle)
            4'b0000: selData = entrada1;
            4'b0001: selData = entrada2;
            4'b0010: selData = entrada3;
            4'b0110: selData = entrada4;
            4'b0111: selData = entrada5;
            4'b1100: selData = entrada6;
            default: begin
                selData    = '0;
                selInvalid = 1'b1;
            end
        endcase
    end

    // zero is derived from the value being loaded so it always tracks saida.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            saida           <= '0;
            selecaoInvalida <= 1'b0;
            zero            <= 1'b1;
        end else if (habilita) begin
            saida           <= selData;
            selecaoInvalida <= selInvalid;
            zero            <= (selData == '0);
        end
    end

endmodule

// File: tb/tb_mux6_1.sv
// Bench for mux6_1: directed scenarios plus randomized traffic against a table-driven reference model.
module tb_mux6_1;

    logic        clock;
    logic        reset;
    logic [31:0] din [6];
    logic [0:3]  code;
    logic        hab;
    logic [31:0] saida;
    logic        selecaoInvalida;
    logic        zero;

    int checks = 0;
    int failures = 0;

    logic [31:0] expSaida;
    logic        expInv;
    logic        expZero;

    localparam logic [3:0] MAPPED [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

    mux6_1 #(.WIDTH(32)) dut (
        .clock(clock),
        .reset(reset),
        .entrada1(din[0]),
        .entrada2(din[1]),
        .entrada3(din[2]),
        .entrada4(din[3]),
        .entrada5(din[4]),
        .entrada6(din[5]),
        .unidadeControle(code),
        .saida(saida),
        .habilita(hab),
        .selecaoInvalida(selecaoInvalida),
        .zero(zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, ".saida"}, saida, expSaida);
        check({tag, ".inv"}, {31'b0, selecaoInvalida}, {31'b0, expInv});
        check({tag, ".zero"}, {31'b0, zero}, {31'b0, expZero});
    endtask

    // Reference: look the code up in the mapping table; anything not found is invalid.
    task automatic modelEdge();
        logic        found;
        logic [31:0] val;
        logic [3:0]  c;
        if (reset) begin
            expSaida = '0;
            expInv   = 1'b0;
            expZero  = 1'b1;
        end else if (hab) begin
            c     = code;
            found = 1'b0;
            val   = '0;
            for (int i = 0; i < 6; i++) begin
                if (c === MAPPED[i]) begin
                    found = 1'b1;
                    val   = din[i];
                end
            end
            expSaida = val;
            expInv   = !found;
            expZero  = (val == 32'd0);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clock);
        modelEdge();
        #1;
        checkAll(tag);
    endtask

    task automatic setStd();
        din[0] = 32'h11111111;
        din[1] = 32'h22222222;
        din[2] = 32'h33333333;
        din[3] = 32'h44444444;
        din[4] = 32'h55555555;
        din[5] = 32'h66666666;
    endtask

    initial begin
        reset = 1'b1;
        hab   = 1'b1;
        code  = 4'b0010;
        for (int i = 0; i < 6; i++) din[i] = 32'hA5A5A5A5;
        expSaida = '0;
        expInv   = 1'b0;
        expZero  = 1'b1;

        // Reset held across edges, with a load request present
        cycle("reset0");
        cycle("reset1");
        #2 reset = 1'b0;

        // Basic selection of entrada3
        setStd();
        code = 4'b0010;
        hab  = 1'b1;
        cycle("sel0010");

        // Sweep the remaining mapped codes
        code = 4'b0000; cycle("sel0000");
        code = 4'b0001; cycle("sel0001");
        code = 4'b0110; cycle("sel0110");
        code = 4'b0111; cycle("sel0111");
        code = 4'b1100; cycle("sel1100");

        // Unmapped code, then back to valid
        code = 4'b0011; cycle("inv0011");
        code = 4'b0000; cycle("back0000");

        // Mapped source carrying zero
        din[3] = 32'd0;
        code = 4'b0110; cycle("zeroData");

        // Hold with enable low while everything changes
        setStd();
        code = 4'b0111; cycle("preHold");
        hab = 1'b0;
        for (int k = 0; k < 3; k++) begin
            code = 4'($urandom_range(0, 15));
            for (int i = 0; i < 6; i++) din[i] = $urandom;
            cycle("hold");
        end

        // Asynchronous reset between edges
        setStd();
        hab  = 1'b1;
        code = 4'b0111;
        cycle("pre55");
        #3 reset = 1'b1;
        #1;
        expSaida = '0;
        expInv   = 1'b0;
        expZero  = 1'b1;
        checkAll("asyncRst");

        // Reset wins over a simultaneous load
        code = 4'b1100;
        cycle("rstOverride");
        reset = 1'b0;
        code  = 4'b1100;
        cycle("afterRst");

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 6; i++)
                din[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 2) == 0)
                code = 4'($urandom_range(0, 15));
            else
                code = MAPPED[$urandom_range(0, 5)];
            hab   = ($urandom_range(0, 4) != 0);
            reset = ($urandom_range(0, 39) == 0);
            cycle("rand");
            reset = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux6_1.md
MUX6_1 -- requirements
Module: mux6_1

Interface
REQ-001 Parameter: WIDTH, default 32, bit width of every data input and of saida.
REQ-002 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: entrada1  input  WIDTH  data source 1 (AND result).
REQ-005 Port: entrada2  input  WIDTH  data source 2 (OR result).
REQ-006 Port: entrada3  input  WIDTH  data source 3 (ADD result).
REQ-007 Port: entrada4  input  WIDTH  data source 4 (SUB result).
REQ-008 Port: entrada5  input  WIDTH  data source 5 (SLT result).
REQ-009 Port: entrada6  input  WIDTH  data source 6 (NOR result).
REQ-010 Port: unidadeControle  input  4, declared [0:3]  select code; bit 0 is the MSB.
REQ-011 Port: saida  output  WIDTH  registered selected data.
REQ-012 Port: habilita  input  1  load enable; when 0, all registered outputs hold.
REQ-013 Port: selecaoInvalida  output  1  registered flag; 1 when the last loaded code was unmapped.
REQ-014 Port: zero  output  1  registered flag; 1 when the registered saida equals 0.
REQ-015 Port order: clock, reset, entrada1..entrada6, unidadeControle, saida, habilita, selecaoInvalida, zero.
REQ-016 Inputs narrower than WIDTH shall be zero-extended by the connecting module; the mux performs no sign extension.

Function
REQ-017 Code 0000 shall select entrada1.
REQ-018 Code 0001 shall select entrada2.
REQ-019 Code 0010 shall select entrada3.
REQ-020 Code 0110 shall select entrada4.
REQ-021 Code 0111 shall select entrada5.
REQ-022 Code 1100 shall select entrada6.
REQ-023 Any of the other 10 codes shall select all-zeros and set selecaoInvalida to 1; a mapped code sets it to 0.
REQ-024 On a rising clock edge with habilita=1 and reset=0, saida, selecaoInvalida and zero shall load from the current inputs and code.
REQ-025 Latency: exactly 1 cycle from sampled inputs to saida; there is no combinational path from any input to any output.
REQ-026 With habilita=0, all outputs shall hold their values, regardless of any change on the data inputs or the code.
REQ-027 zero shall be computed from the value loaded into saida in the same edge, so that it is always consistent with saida; an invalid code therefore yields zero=1.
REQ-028 Data shall pass bit-exact with no arithmetic, inversion or reordering.
REQ-029 X or Z bits on unidadeControle shall be treated as an invalid code: select zeros, selecaoInvalida=1.

Reset
REQ-030 While reset=1: saida=0, selecaoInvalida=0, zero=1, applied immediately without waiting for a clock edge, and held for as long as reset stays high.
REQ-031 After reset falls, the first rising edge with habilita=1 shall load normally.
REQ-032 Reset asserted mid-operation shall override a simultaneous load on the same edge.

Verification
REQ-033 entrada1..6 = 0x11111111, 0x22222222, 0x33333333, 0x44444444, 0x55555555, 0x66666666; code 0010, habilita=1 -> after 1 edge, saida=0x33333333, zero=0, selecaoInvalida=0.
REQ-034 Same data, sweep the codes 0000/0001/0110/0111/1100 -> saida = 0x11111111/0x22222222/0x44444444/0x55555555/0x66666666, each one cycle after its code.
REQ-035 Code 0011 -> saida=0, selecaoInvalida=1, zero=1; then code 0000 -> selecaoInvalida returns to 0.
REQ-036 entrada4=0, code 0110 -> saida=0, zero=1, selecaoInvalida=0.
REQ-037 habilita=0, change code and all data -> saida unchanged across 3 edges.
REQ-038 Assert reset between clock edges while saida=0x55555555 -> saida=0 and zero=1 before the next edge.
